// File: rtl/sp_pkg.sv
// Shared types for the issue/execute slice: datapath width, function codes
// and the decoded instruction bundle handed to operand_fetch.
package sp_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int NUM_REGS_DEFAULT = 16;
    localparam int REG_AW           = $clog2(NUM_REGS_DEFAULT);

    typedef enum logic [3:0] {
        FUNC_AND   = 4'h0,
        FUNC_OR    = 4'h1,
        FUNC_XOR   = 4'h2,
        FUNC_NOT   = 4'h3,
        FUNC_ADD   = 4'h4,
        FUNC_SUB   = 4'h5,
        FUNC_SLL   = 4'h6,
        FUNC_SRL   = 4'h7,
        FUNC_SRA   = 4'h8,
        FUNC_SLT   = 4'h9,
        FUNC_SLTU  = 4'hA,
        FUNC_PASSA = 4'hB,
        FUNC_PASSB = 4'hC,
        FUNC_NAND  = 4'hD,
        FUNC_NOR   = 4'hE,
        FUNC_XNOR  = 4'hF
    } func_t;

    typedef struct packed {
        func_t             func;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_t;

    // A register is still busy unless this cycle's writeback retires it.
    function automatic logic still_pending(input logic [NUM_REGS_DEFAULT-1:0] pend,
                                           input logic [REG_AW-1:0]           addr,
                                           input logic                        wb_live,
                                           input logic [REG_AW-1:0]           wb_addr);
        return pend[addr] & ~(wb_live & (wb_addr == addr));
    endfunction

endpackage

// File: rtl/sp_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// register 0 hardwired to zero.
module sp_regfile
    import sp_pkg::*;
#(
    parameter int  NUM_REGS = NUM_REGS_DEFAULT,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr1_i,
    input  logic [AW-1:0]         raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Next-state of the array; address 0 is forced back to zero every cycle.
    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != {AW{1'b0}})) begin
            regs_d[waddr_i] = wdata_i;
        end else begin
            regs_d[waddr_i] = regs_q[waddr_i];
        end
        regs_d[0] = {DATA_WIDTH{1'b0}};
    end

    // Storage update with asynchronous clear.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1_o = (raddr1_i == {AW{1'b0}}) ? {DATA_WIDTH{1'b0}} : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == {AW{1'b0}}) ? {DATA_WIDTH{1'b0}} : regs_q[raddr2_i];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: register read with writeback bypass, pending-write scoreboard
// and a one-entry registered operand bundle towards the execute units.
module operand_fetch
    import sp_pkg::*;
#(
    parameter int  NUM_REGS = NUM_REGS_DEFAULT,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  instr_t                instr_i,
    input  logic                  wb_en_i,
    input  logic [AW-1:0]         wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output func_t                 opcode_o,
    output logic [AW-1:0]         rd_o,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output logic [NUM_REGS-1:0]   pending_o
);

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  op_valid_q, op_valid_d;
    func_t                 opcode_q, opcode_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;

    logic [DATA_WIDTH-1:0] rf_rs1_s, rf_rs2_s;
    logic [DATA_WIDTH-1:0] rs1_val_s, rs2_val_s;
    logic                  wb_live_s;
    logic                  hazard_s;
    logic                  ready_s;
    logic                  accept_s;

    sp_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .we_i     (wb_en_i),
        .waddr_i  (wb_addr_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (instr_i.rs1),
        .raddr2_i (instr_i.rs2),
        .rdata1_o (rf_rs1_s),
        .rdata2_o (rf_rs2_s)
    );

    // Hazard detection, handshake and writeback bypass of the read data.
    always_comb begin
        wb_live_s = wb_en_i & (wb_addr_i != {AW{1'b0}});
        hazard_s  = still_pending(pending_q, instr_i.rs1, wb_live_s, wb_addr_i)
                  | still_pending(pending_q, instr_i.rs2, wb_live_s, wb_addr_i)
                  | still_pending(pending_q, instr_i.rd,  wb_live_s, wb_addr_i);
        ready_s   = (~op_valid_q | op_ready_i) & ~hazard_s;
        accept_s  = instr_valid_i & ready_s;
        if (wb_live_s && (wb_addr_i == instr_i.rs1)) begin
            rs1_val_s = wb_data_i;
        end else begin
            rs1_val_s = rf_rs1_s;
        end
        if (wb_live_s && (wb_addr_i == instr_i.rs2)) begin
            rs2_val_s = wb_data_i;
        end else begin
            rs2_val_s = rf_rs2_s;
        end
    end

    // Next bundle and scoreboard; a set on accept overrides a same-address clear.
    always_comb begin
        op_valid_d = op_valid_q;
        opcode_d   = opcode_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        pending_d  = pending_q;
        if (accept_s) begin
            op_valid_d = 1'b1;
            opcode_d   = instr_i.func;
            rd_d       = instr_i.rd;
            rs1_d      = rs1_val_s;
            rs2_d      = rs2_val_s;
        end else if (op_valid_q && op_ready_i) begin
            op_valid_d = 1'b0;
        end else begin
            op_valid_d = op_valid_q;
        end
        if (wb_live_s) begin
            pending_d[wb_addr_i] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (accept_s && (instr_i.rd != {AW{1'b0}})) begin
            pending_d[instr_i.rd] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // Bundle and scoreboard state.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            op_valid_q <= 1'b0;
            opcode_q   <= FUNC_AND;
            rd_q       <= {AW{1'b0}};
            rs1_q      <= {DATA_WIDTH{1'b0}};
            rs2_q      <= {DATA_WIDTH{1'b0}};
            pending_q  <= {NUM_REGS{1'b0}};
        end else begin
            op_valid_q <= op_valid_d;
            opcode_q   <= opcode_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            pending_q  <= pending_d;
        end
    end

    assign instr_ready_o = ready_s;
    assign op_valid_o    = op_valid_q;
    assign opcode_o      = opcode_q;
    assign rd_o          = rd_q;
    assign rs1_data_o    = rs1_q;
    assign rs2_data_o    = rs2_q;
    assign pending_o     = pending_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios, then random
// traffic, all compared against a register/scoreboard model held here.
module tb_operand_fetch;
    import sp_pkg::*;

    localparam int NR = 16;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    instr_t      instr_i;
    logic        wb_en_i;
    logic [3:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        op_valid_o;
    logic        op_ready_i;
    func_t       opcode_o;
    logic [3:0]  rd_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [15:0] pending_o;

    operand_fetch #(.NUM_REGS(NR)) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .op_valid_o    (op_valid_o),
        .op_ready_i    (op_ready_i),
        .opcode_o      (opcode_o),
        .rd_o          (rd_o),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .pending_o     (pending_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference state: architectural registers, busy flags, visible bundle.
    logic [31:0] m_regs [NR];
    bit          m_pend [NR];
    bit          m_valid;
    logic [3:0]  m_op;
    logic [3:0]  m_rd;
    logic [31:0] m_a;
    logic [31:0] m_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_op    = 4'h0;
        m_rd    = 4'h0;
        m_a     = 32'h0;
        m_b     = 32'h0;
    endtask

    function automatic bit m_busy(input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
        if (wb_en_i && wb_addr_i == r) return 1'b0;
        return m_pend[r];
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] r);
        if (r == 4'd0) return 32'h0;
        if (wb_en_i && wb_addr_i == r) return wb_data_i;
        return m_regs[r];
    endfunction

    task automatic check_outputs();
        logic [15:0] exp_pend;
        for (int i = 0; i < NR; i++) exp_pend[i] = m_pend[i];
        chk("op_valid", op_valid_o, m_valid);
        chk("opcode", opcode_o, m_op);
        chk("rd", rd_o, m_rd);
        chk("rs1_data", rs1_data_o, m_a);
        chk("rs2_data", rs2_data_o, m_b);
        chk("pending", pending_o, exp_pend);
    endtask

    // Inputs are already driven; check ready, clock once, update model, check.
    task automatic step();
        bit          exp_rdy;
        bit          acc;
        logic [31:0] a;
        logic [31:0] b;
        #1;
        exp_rdy = (!m_valid || op_ready_i)
                  && !(m_busy(instr_i.rs1) || m_busy(instr_i.rs2) || m_busy(instr_i.rd));
        chk("instr_ready", instr_ready_o, exp_rdy);
        acc = instr_valid_i && exp_rdy;
        a   = m_read(instr_i.rs1);
        b   = m_read(instr_i.rs2);
        @(posedge clk_i);
        if (acc) begin
            m_valid = 1'b1;
            m_op    = instr_i.func;
            m_rd    = instr_i.rd;
            m_a     = a;
            m_b     = b;
        end else if (m_valid && op_ready_i) begin
            m_valid = 1'b0;
        end
        if (wb_en_i && wb_addr_i != 4'd0) begin
            m_regs[wb_addr_i] = wb_data_i;
            m_pend[wb_addr_i] = 1'b0;
        end
        if (acc && instr_i.rd != 4'd0) m_pend[instr_i.rd] = 1'b1;
        #1;
        check_outputs();
        @(negedge clk_i);
    endtask

    task automatic issue(input bit v, input logic [3:0] f, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
        instr_valid_i = v;
        instr_i.func  = func_t'(f);
        instr_i.rd    = rd;
        instr_i.rs1   = rs1;
        instr_i.rs2   = rs2;
    endtask

    task automatic wb(input bit en, input logic [3:0] addr, input logic [31:0] data);
        wb_en_i   = en;
        wb_addr_i = addr;
        wb_data_i = data;
    endtask

    initial begin
        logic [31:0] held;
        arst_i     = 1'b1;
        op_ready_i = 1'b1;
        issue(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
        wb(1'b0, 4'd0, 32'h0);
        m_reset();
        #1;
        check_outputs();
        @(negedge clk_i);
        arst_i = 1'b0;

        step();

        wb(1'b1, 4'd3, 32'hA5A5_0F0F);
        step();
        wb(1'b0, 4'd0, 32'h0);
        issue(1'b1, 4'b0101, 4'd4, 4'd3, 4'd0);
        step();
        chk("wb_read_rs1", rs1_data_o, 32'hA5A5_0F0F);
        chk("wb_read_rs2", rs2_data_o, 32'h0);
        chk("wb_read_op", opcode_o, 4'b0101);
        chk("wb_read_pend4", pending_o[4], 1'b1);

        issue(1'b1, 4'h4, 4'd8, 4'd5, 4'd0);
        wb(1'b1, 4'd5, 32'h0000_1234);
        step();
        chk("bypass_rs1", rs1_data_o, 32'h0000_1234);
        wb(1'b0, 4'd0, 32'h0);

        issue(1'b1, 4'h1, 4'd6, 4'd0, 4'd0);
        step();
        issue(1'b1, 4'h2, 4'd9, 4'd6, 4'd0);
        step();
        chk("raw_stall_ready", instr_ready_o, 1'b0);
        step();
        wb(1'b1, 4'd6, 32'h0000_0055);
        #1;
        chk("raw_release_ready", instr_ready_o, 1'b1);
        step();
        chk("raw_bypass_rs1", rs1_data_o, 32'h0000_0055);
        wb(1'b0, 4'd0, 32'h0);

        // Backpressure: bundle must stay frozen while execute is not ready.
        held       = rs1_data_o;
        op_ready_i = 1'b0;
        issue(1'b1, 4'h7, 4'd10, 4'd3, 4'd0);
        for (int i = 0; i < 3; i++) step();
        chk("bp_hold_rs1", rs1_data_o, held);
        chk("bp_hold_rd", rd_o, 4'd9);
        op_ready_i = 1'b1;
        step();
        chk("bp_next_rd", rd_o, 4'd10);
        chk("bp_next_rs1", rs1_data_o, 32'hA5A5_0F0F);

        issue(1'b1, 4'h0, 4'd0, 4'd0, 4'd0);
        wb(1'b1, 4'd0, 32'h0000_FFFF);
        step();
        chk("r0_bypass", rs1_data_o, 32'h0);
        wb(1'b0, 4'd0, 32'h0);
        step();
        chk("r0_read", rs1_data_o, 32'h0);

        issue(1'b1, 4'h3, 4'd7, 4'd0, 4'd0);
        wb(1'b1, 4'd7, 32'hDEAD_BEEF);
        step();
        chk("set_wins_pend7", pending_o[7], 1'b1);

        for (int n = 0; n < 600; n++) begin
            issue($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
            wb($urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), $urandom);
            op_ready_i = $urandom_range(0, 3) != 0;
            step();
        end

        op_ready_i = 1'b0;
        issue(1'b1, 4'h5, 4'd12, 4'd0, 4'd0);
        wb(1'b0, 4'd0, 32'h0);
        step();
        arst_i = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_valid", op_valid_o, 1'b0);
        chk("mid_rst_pending", pending_o, 16'h0);
        check_outputs();
        instr_valid_i = 1'b0;
        op_ready_i    = 1'b1;
        #2;
        arst_i = 1'b0;
        @(negedge clk_i);
        issue(1'b1, 4'h6, 4'd2, 4'd3, 4'd4);
        step();
        chk("post_rst_rs1", rs1_data_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
